hazard_ctrl: RTL and testbench

//  Drives stall/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and PC hold.

---
 rtl/hazard_ctrl_pkg.sv | 38 +++
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_wait_timer.sv | 41 ++++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, control bundle, load-use helper.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned PERF_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_bubble;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
    logic exmem_bubble;
    logic memwb_bubble;
    logic mem_timeout;
  } hz_ctl_t;

  // Load in EX whose nonzero destination feeds a source of the instruction in ID.
  function automatic logic load_use_hit(input logic             memtoreg,
                                        input logic             regwr,
                                        input logic [REG_W-1:0] ex_rt,
                                        input logic [REG_W-1:0] id_rs,
                                        input logic [REG_W-1:0] id_rt,
                                        input logic             uses_rt);
    return memtoreg & regwr & (ex_rt != REG_ZERO) &
           ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals and the stall/bubble controls returned to the pipeline registers.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0]  id_Rs;
  logic [REG_W-1:0]  id_Rt;
  logic              id_uses_rt;
  logic              ex_MemtoReg;
  logic              ex_RegWr;
  logic [REG_W-1:0]  ex_Rt;
  logic              ex_Jump;
  logic              mem_branch_taken;
  logic              mem_MemRd;
  logic              mem_MemWr;
  logic              dmem_ready;

  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_bubble;
  logic              idex_stall;
  logic              idex_bubble;
  logic              exmem_stall;
  logic              exmem_bubble;
  logic              memwb_bubble;
  logic              mem_timeout;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;

  modport master (
    output id_Rs, id_Rt, id_uses_rt, ex_MemtoReg, ex_RegWr, ex_Rt, ex_Jump,
           mem_branch_taken, mem_MemRd, mem_MemWr, dmem_ready,
    input  pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
           exmem_stall, exmem_bubble, memwb_bubble, mem_timeout,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_Rs, id_Rt, id_uses_rt, ex_MemtoReg, ex_RegWr, ex_Rt, ex_Jump,
           mem_branch_taken, mem_MemRd, mem_MemWr, dmem_ready,
    output pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
           exmem_stall, exmem_bubble, memwb_bubble, mem_timeout,
           perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/hazard_wait_timer.sv
// Counts consecutive data-memory wait cycles; expired_o flags that this wait cycle reaches WAIT_TIMEOUT.
module hazard_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 2);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // Saturating so a disabled timeout never wraps.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr_i) begin
      wait_cnt_d = '0;
    end else if (load_i) begin
      wait_cnt_d = CNT_W'(1);
    end else if (inc_i && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expired_o = (WAIT_TIMEOUT != 0) &&
                     ((32'(wait_cnt_q) + 32'd1) >= 32'(WAIT_TIMEOUT));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble generator for the 5-stage pipeline (load-use, branch, jump, dmem wait).
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned FLUSH_HOLD   = 0
) (
  input  logic           Clk,
  input  logic           Reset,
  hazard_ctrl_if.slave   hz
);

  localparam int unsigned FL_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD + 1) : 1;

  localparam hz_ctl_t CTL_FREEZE = '{pc_stall: 1'b1, ifid_stall: 1'b1, idex_stall: 1'b1,
                                     exmem_stall: 1'b1, memwb_bubble: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_BRANCH = '{ifid_bubble: 1'b1, idex_bubble: 1'b1,
                                     exmem_bubble: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_JUMP   = '{ifid_bubble: 1'b1, idex_bubble: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_LDUSE  = '{pc_stall: 1'b1, ifid_stall: 1'b1, idex_bubble: 1'b1,
                                     default: 1'b0};
  localparam hz_ctl_t CTL_RESET  = '{ifid_bubble: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b1,
                                     memwb_bubble: 1'b1, default: 1'b0};

  state_e          state_q, state_d;
  logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
  hz_ctl_t         ctl;
  logic            memwait_c;
  logic            eval_rest_c;
  logic            tmr_load, tmr_inc, tmr_clr, tmr_expired;

  hazard_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk       (Clk),
    .rst       (Reset),
    .load_i    (tmr_load),
    .inc_i     (tmr_inc),
    .clr_i     (tmr_clr),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and same-cycle pipeline controls.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ctl         = '0;
    eval_rest_c = 1'b0;
    tmr_load    = 1'b0;
    tmr_inc     = 1'b0;
    tmr_clr     = 1'b0;
    memwait_c   = (hz.mem_MemRd | hz.mem_MemWr) & ~hz.dmem_ready;

    case (state_q)
      ST_RUN: begin
        if (memwait_c) begin
          ctl      = CTL_FREEZE;
          state_d  = ST_MWAIT;
          tmr_load = 1'b1;
        end else begin
          eval_rest_c = 1'b1;
        end
      end
      ST_MWAIT: begin
        if (!hz.dmem_ready) begin
          ctl = CTL_FREEZE;
          if (tmr_expired) begin
            state_d = ST_ERROR;
          end else begin
            tmr_inc = 1'b1;
          end
        end else begin
          state_d     = ST_RUN;
          tmr_clr     = 1'b1;
          eval_rest_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        ctl.ifid_bubble = 1'b1;
        flush_cnt_d     = flush_cnt_q - FL_W'(1);
        if (flush_cnt_q <= FL_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        ctl             = CTL_FREEZE;
        ctl.mem_timeout = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // The older branch in MEM squashes whatever jump or load-use sits behind it.
    if (eval_rest_c) begin
      if (hz.mem_branch_taken) begin
        ctl = CTL_BRANCH;
        if (FLUSH_HOLD > 0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FL_W'(FLUSH_HOLD);
        end
      end else if (hz.ex_Jump) begin
        ctl = CTL_JUMP;
      end else if (load_use_hit(hz.ex_MemtoReg, hz.ex_RegWr, hz.ex_Rt,
                                hz.id_Rs, hz.id_Rt, hz.id_uses_rt)) begin
        ctl = CTL_LDUSE;
      end
    end

    if (Reset) begin
      ctl = CTL_RESET;
    end
  end

  assign hz.pc_stall     = ctl.pc_stall;
  assign hz.ifid_stall   = ctl.ifid_stall;
  assign hz.ifid_bubble  = ctl.ifid_bubble;
  assign hz.idex_stall   = ctl.idex_stall;
  assign hz.idex_bubble  = ctl.idex_bubble;
  assign hz.exmem_stall  = ctl.exmem_stall;
  assign hz.exmem_bubble = ctl.exmem_bubble;
  assign hz.memwb_bubble = ctl.memwb_bubble;
  assign hz.mem_timeout  = ctl.mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
  logic              flush_evt_c;

  assign flush_evt_c = eval_rest_c & (hz.mem_branch_taken | hz.ex_Jump);

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (ctl.pc_stall && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + PERF_W'(1);
    end
    if (flush_evt_c && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + PERF_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (WAIT_TIMEOUT=4, FLUSH_HOLD=2); honours HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam int unsigned WT = 4;
  localparam int unsigned FH = 2;

  // Expected control vector order:
  // {pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble, exmem_stall, exmem_bubble, memwb_bubble, mem_timeout}
  localparam logic [8:0] O_NONE   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_LU     = 9'b1_1_0_0_1_0_0_0_0;
  localparam logic [8:0] O_BR     = 9'b0_0_1_0_1_0_1_0_0;
  localparam logic [8:0] O_JMP    = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] O_FRZ    = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] O_FRZ_TO = 9'b1_1_0_1_0_1_0_1_1;
  localparam logic [8:0] O_FL     = 9'b0_0_1_0_0_0_0_0_0;
  localparam logic [8:0] O_RST    = 9'b0_0_1_0_1_0_1_1_0;

`ifdef HAZARD_PERF_EN
  localparam int unsigned EXP_STALLS  = 3;
  localparam int unsigned EXP_FLUSHES = 2;
`else
  localparam int unsigned EXP_STALLS  = 0;
  localparam int unsigned EXP_FLUSHES = 0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(
    .WAIT_TIMEOUT (WT),
    .FLUSH_HOLD   (FH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz_if)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       m2r;
    logic       rw;
    logic [4:0] exrt;
    logic       jmp;
    logic       br;
    logic       rd;
    logic       wr;
    logic       rdy;
  } vin_t;

  typedef struct {
    string      name;
    vin_t       in;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  function automatic vin_t mk(input int rs, input int rt, input bit urt, input bit m2r,
                              input bit rw, input int exrt, input bit jmp, input bit br,
                              input bit rd, input bit wr, input bit rdy);
    vin_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urt = urt; v.m2r = m2r; v.rw = rw;
    v.exrt = 5'(exrt); v.jmp = jmp; v.br = br; v.rd = rd; v.wr = wr; v.rdy = rdy;
    return v;
  endfunction

  task automatic drive(input vin_t v);
    hz_if.id_Rs            = v.rs;
    hz_if.id_Rt            = v.rt;
    hz_if.id_uses_rt       = v.urt;
    hz_if.ex_MemtoReg      = v.m2r;
    hz_if.ex_RegWr         = v.rw;
    hz_if.ex_Rt            = v.exrt;
    hz_if.ex_Jump          = v.jmp;
    hz_if.mem_branch_taken = v.br;
    hz_if.mem_MemRd        = v.rd;
    hz_if.mem_MemWr        = v.wr;
    hz_if.dmem_ready       = v.rdy;
  endtask

  function automatic logic [8:0] dut_out();
    return {hz_if.pc_stall, hz_if.ifid_stall, hz_if.ifid_bubble, hz_if.idex_stall,
            hz_if.idex_bubble, hz_if.exmem_stall, hz_if.exmem_bubble, hz_if.memwb_bubble,
            hz_if.mem_timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // One clock: drive at posedge+1, record expectation, compare at the falling edge.
  task automatic step(input string name, input vin_t v, input logic [8:0] exp);
    sb_t e;
    drive(v);
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(negedge Clk);
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(e.name, 32'(dut_out()), 32'(e.exp));
    end
    @(posedge Clk);
    #1;
  endtask

  vin_t idle, luv, mw, brall, brv;
  vec_t tbl[11];

  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    luv   = mk(2, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1);
    mw    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    brall = mk(2, 0, 0, 1, 1, 2, 1, 1, 0, 0, 1);
    brv   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

    tbl[0]  = '{"idle",         idle,                               O_NONE};
    tbl[1]  = '{"lu_rs",        luv,                                O_LU};
    tbl[2]  = '{"lu_clear",     idle,                               O_NONE};
    tbl[3]  = '{"lu_rt",        mk(5, 2, 1, 1, 1, 2, 0, 0, 0, 0, 1), O_LU};
    tbl[4]  = '{"rt_unused",    mk(5, 2, 0, 1, 1, 2, 0, 0, 0, 0, 1), O_NONE};
    tbl[5]  = '{"rt_zero",      mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1), O_NONE};
    tbl[6]  = '{"no_regwr",     mk(2, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1), O_NONE};
    tbl[7]  = '{"not_load",     mk(2, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1), O_NONE};
    tbl[8]  = '{"jump",         mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), O_JMP};
    tbl[9]  = '{"jump_over_lu", mk(2, 0, 0, 1, 1, 2, 1, 0, 0, 0, 1), O_JMP};
    tbl[10] = '{"rd_ready_lu",  mk(2, 0, 0, 1, 1, 2, 0, 0, 1, 0, 1), O_LU};

    // Reset holds every register bubbled regardless of hazards.
    Reset = 1'b1;
    drive(luv);
    #1;
    step("reset_ctl", luv, O_RST);
    Reset = 1'b0;
    check("reset_perf_stall", hz_if.perf_stall_cnt, 32'd0);
    check("reset_perf_flush", hz_if.perf_flush_cnt, 32'd0);

    for (int i = 0; i < 11; i++) step(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Branch beats jump and load-use, then FLUSH_HOLD extra IF/ID bubbles.
    step("br_prio", brall, O_BR);
    step("flush_1", brall, O_FL);
    step("flush_2", luv, O_FL);
    step("flush_done", idle, O_NONE);

    // Three wait cycles, then release into RUN.
    for (int i = 0; i < 3; i++) step($sformatf("mwait_%0d", i), mw, O_FRZ);
    step("mwait_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_NONE);
    step("after_mwait_lu", luv, O_LU);
    step("mwait_wr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_FRZ);
    step("mwait_ready_jmp", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1), O_JMP);

    // Timeout: four wait cycles, error from the fifth, sticky.
    for (int i = 0; i < 4; i++) step($sformatf("tmo_wait_%0d", i), mw, O_FRZ);
    step("tmo_cycle5", mw, O_FRZ_TO);
    step("tmo_sticky_1", idle, O_FRZ_TO);
    step("tmo_sticky_2", luv, O_FRZ_TO);

    // Asynchronous reset mid-cycle clears the error at once.
    Reset = 1'b1;
    #1;
    check("async_rst", 32'(dut_out()), 32'(O_RST));
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step("post_err_idle", idle, O_NONE);
    step("post_err_mw", mw, O_FRZ);
    step("post_err_rdy", idle, O_NONE);

    // Performance counters from a clean reset: 3 load-use stalls, 2 branch flushes.
    Reset = 1'b1;
    #1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("perf_lu_%0d", i), luv, O_LU);
      step($sformatf("perf_gap_%0d", i), idle, O_NONE);
    end
    for (int i = 0; i < 2; i++) begin
      step($sformatf("perf_br_%0d", i), brv, O_BR);
      step($sformatf("perf_fl_a_%0d", i), idle, O_FL);
      step($sformatf("perf_fl_b_%0d", i), idle, O_FL);
    end
    check("perf_stall_cnt", hz_if.perf_stall_cnt, 32'(EXP_STALLS));
    check("perf_flush_cnt", hz_if.perf_flush_cnt, 32'(EXP_FLUSHES));

    // Reset inside FLUSH returns to RUN and clears the counters.
    step("rf_branch", brv, O_BR);
    Reset = 1'b1;
    step("rf_reset", idle, O_RST);
    Reset = 1'b0;
    step("rf_run", idle, O_NONE);
    check("rf_perf_stall", hz_if.perf_stall_cnt, 32'd0);
    check("rf_perf_flush", hz_if.perf_flush_cnt, 32'd0);

    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
